apb_master_ctrl: RTL and testbench

APB4 master transfer engine for the AXI4Lite-to-APB4 bridge, directly downstream of the APB access arbiter. It accepts one-cycle read/write grants (`rd_en`/`wr_en`) and pops the request from the read-address or write-address/data FIFO. It then runs the APB4 SETUP/ACCESS sequence and returns a registered completion pulse (`rd`/`wr`) to the arbiter, plus a response word to the AXI read-data or write-response path. It also enforces a PREADY timeout so a hung slave cannot stall the bridge.

---
 rtl/apb_bridge_pkg.sv | 19 +
 rtl/apb_master_ctrl_if.sv | 53 +++++
 rtl/apb_timeout_cnt.sv | 28 ++
 rtl/apb_master_ctrl.sv | 154 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AXI4Lite-to-APB4 bridge.
package apb_bridge_pkg;

  // One-hot transfer state, consistent with the arbiter's encoding style.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } apb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI response word from an error flag: {err, 1'b0}.
  function automatic logic [1:0] resp_enc(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bus bundle for apb_master_ctrl: arbiter grants, FIFO heads/pops, APB4 and responses.
interface apb_master_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    rd_en;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    ar_pop;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    aw_pop;
  logic                    w_pop;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;
  logic                    rd;
  logic                    wr;
  logic                    r_push;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    b_push;
  logic [1:0]              b_resp;
  logic                    protocol_err;

  // Transfer engine view.
  modport master (
    input  rd_en, wr_en, araddr, arprot, awaddr, awprot, wdata, wstrb,
    input  pready, prdata, pslverr,
    output ar_pop, aw_pop, w_pop,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output rd, wr, r_push, r_data, r_resp, b_push, b_resp, protocol_err
  );

  // Surrounding logic view: arbiter, FIFOs, APB slave and response paths.
  modport slave (
    output rd_en, wr_en, araddr, arprot, awaddr, awprot, wdata, wstrb,
    output pready, prdata, pslverr,
    input  ar_pop, aw_pop, w_pop,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  rd, wr, r_push, r_data, r_resp, b_push, b_resp, protocol_err
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles with PREADY low; hit_o flags the last permitted cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  if (TIMEOUT > 0) begin : g_cnt
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // Wait-cycle counter, cleared as the transfer enters ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)         cnt_q <= '0;
      else if (clear_i)  cnt_q <= '0;
      else if (enable_i) cnt_q <= cnt_q + CW'(1);
    end

    assign hit_o = (cnt_q == CW'(TIMEOUT - 1));
  end else begin : g_off
    assign hit_o = 1'b0;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master transfer engine: grant -> SETUP -> ACCESS -> registered response.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                clk,
  input logic                rstn,
  apb_master_ctrl_if.master  bus
);

  localparam int unsigned SW = DATA_WIDTH / 8;

  apb_state_e state_q, state_d;

  logic                  take_rd, take_wr, done, tmo, proto_err_d;
  logic                  cnt_clear, cnt_en, cnt_hit;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            pprot_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         pstrb_q;

  logic                  rd_q, wr_q, proto_err_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q, b_resp_q;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .hit_o    (cnt_hit)
  );

  // Next-state, grant acceptance, completion and illegal-grant detection.
  always_comb begin
    state_d     = state_q;
    take_rd     = 1'b0;
    take_wr     = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
    proto_err_d = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rd_en) begin
          // Read wins a double grant; the write stays queued in its FIFO.
          take_rd     = 1'b1;
          proto_err_d = bus.wr_en;
          state_d     = ST_SETUP;
        end else if (bus.wr_en) begin
          take_wr = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        proto_err_d = bus.rd_en | bus.wr_en;
        cnt_clear   = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        proto_err_d = bus.rd_en | bus.wr_en;
        if (bus.pready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_hit) begin
          done    = 1'b1;
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Request fields captured at grant and held until the next grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (take_rd) begin
      paddr_q  <= bus.araddr;
      pprot_q  <= bus.arprot;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (take_wr) begin
      paddr_q  <= bus.awaddr;
      pprot_q  <= bus.awprot;
      pwrite_q <= 1'b1;
      pwdata_q <= bus.wdata;
      pstrb_q  <= bus.wstrb;
    end
  end

  // Completion pulses and response words, one cycle after the final ACCESS cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      proto_err_q <= 1'b0;
      r_data_q    <= '0;
      r_resp_q    <= RESP_OKAY;
      b_resp_q    <= RESP_OKAY;
    end else begin
      rd_q        <= done & ~pwrite_q;
      wr_q        <= done & pwrite_q;
      proto_err_q <= proto_err_d;
      if (done && !pwrite_q) begin
        r_data_q <= tmo ? '0 : bus.prdata;
        r_resp_q <= resp_enc(tmo | bus.pslverr);
      end
      if (done && pwrite_q) begin
        b_resp_q <= resp_enc(tmo | bus.pslverr);
      end
    end
  end

  assign bus.ar_pop       = (state_q == ST_IDLE) & bus.rd_en;
  assign bus.aw_pop       = take_wr;
  assign bus.w_pop        = take_wr;
  assign bus.psel         = (state_q != ST_IDLE);
  assign bus.penable      = (state_q == ST_ACCESS);
  assign bus.paddr        = paddr_q;
  assign bus.pprot        = pprot_q;
  assign bus.pwrite       = pwrite_q;
  assign bus.pwdata       = pwdata_q;
  assign bus.pstrb        = pstrb_q;
  assign bus.rd           = rd_q;
  assign bus.r_push       = rd_q;
  assign bus.r_data       = r_data_q;
  assign bus.r_resp       = r_resp_q;
  assign bus.wr           = wr_q;
  assign bus.b_push       = wr_q;
  assign bus.b_resp       = b_resp_q;
  assign bus.protocol_err = proto_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a response scoreboard.
module tb_apb_master_ctrl;
  import apb_bridge_pkg::*;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   n_ar     = 0;
  int   n_aw     = 0;
  int   n_w      = 0;
  int   pen_cnt;
  exp_t exp_q[$];
  exp_t mon_e;

  apb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_rsp(input logic is_rd, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.is_rd = is_rd;
    e.data  = data;
    e.resp  = resp;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every response push must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.r_push || bus.b_push) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push actual=r%0d/b%0d expected=none", bus.r_push, bus.b_push);
      end else begin
        mon_e = exp_q.pop_front();
        chk("push_kind_r", 64'(bus.r_push), 64'(mon_e.is_rd));
        chk("push_kind_b", 64'(bus.b_push), 64'(!mon_e.is_rd));
        chk("pulse_rd", 64'(bus.rd), 64'(mon_e.is_rd));
        chk("pulse_wr", 64'(bus.wr), 64'(!mon_e.is_rd));
        if (mon_e.is_rd) begin
          chk("r_data", 64'(bus.r_data), 64'(mon_e.data));
          chk("r_resp", 64'(bus.r_resp), 64'(mon_e.resp));
        end else begin
          chk("b_resp", 64'(bus.b_resp), 64'(mon_e.resp));
        end
      end
    end
  end

  // FIFO pop counters for dropped/duplicated pop detection.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.ar_pop) n_ar++;
      if (bus.aw_pop) n_aw++;
      if (bus.w_pop)  n_w++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.rd_en = 1'b0;  bus.wr_en = 1'b0;
    bus.araddr = '0;   bus.arprot = '0;
    bus.awaddr = '0;   bus.awprot = '0;
    bus.wdata = '0;    bus.wstrb = '0;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;

    // Reset state
    step(); step(); settle();
    chk("reset_ctrl", 64'({bus.psel, bus.penable, bus.pwrite, bus.rd, bus.wr, bus.r_push,
                           bus.b_push, bus.protocol_err, bus.ar_pop, bus.aw_pop, bus.w_pop}), 64'(0));
    chk("reset_paddr", 64'(bus.paddr), 64'(0));
    chk("reset_pwdata", 64'({bus.pwdata, bus.pstrb, bus.pprot}), 64'(0));
    chk("reset_rsp", 64'({bus.r_data, bus.r_resp, bus.b_resp}), 64'(0));
    step(); rstn = 1'b1;

    // Zero-wait read, N = grant cycle
    step(); bus.rd_en = 1'b1; bus.araddr = 32'h40; bus.arprot = 3'b010;
    expect_rsp(1'b1, 32'hDEADBEEF, RESP_OKAY);
    settle();
    chk("t1_ar_pop", 64'(bus.ar_pop), 64'(1));
    chk("t1_aw_pop", 64'(bus.aw_pop), 64'(0));
    chk("t1_psel_n", 64'(bus.psel), 64'(0));
    step(); bus.rd_en = 1'b0; bus.pready = 1'b1; bus.prdata = 32'hDEADBEEF; settle();
    chk("t1_setup", 64'({bus.psel, bus.penable, bus.pwrite}), 64'(3'b100));
    chk("t1_paddr", 64'(bus.paddr), 64'(32'h40));
    chk("t1_pprot", 64'(bus.pprot), 64'(3'b010));
    chk("t1_rd_fields", 64'({bus.pwdata, bus.pstrb}), 64'(0));
    chk("t1_ar_pop_once", 64'(bus.ar_pop), 64'(0));
    step(); settle();
    chk("t1_access", 64'({bus.psel, bus.penable, bus.rd}), 64'(3'b110));

    // N+3: rd pulse, back-to-back write grant with 3 wait states and SLVERR
    step(); bus.pready = 1'b0; bus.wr_en = 1'b1; bus.awaddr = 32'h1000; bus.awprot = 3'b001;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    expect_rsp(1'b0, 32'h0, RESP_SLVERR);
    settle();
    chk("t1_rd_n3", 64'(bus.rd), 64'(1));
    chk("t1_psel_n3", 64'(bus.psel), 64'(0));
    chk("t2_pops", 64'({bus.aw_pop, bus.w_pop, bus.ar_pop}), 64'(3'b110));
    for (int k = 1; k <= 5; k++) begin
      step(); bus.wr_en = 1'b0;
      if (k == 5) begin bus.pready = 1'b1; bus.pslverr = 1'b1; end
      settle();
      if (k == 1) chk("t1_rd_one_cycle", 64'(bus.rd), 64'(0));
      chk("t2_psel", 64'(bus.psel), 64'(1));
      chk("t2_penable", 64'(bus.penable), 64'(k >= 2));
      chk("t2_pwrite", 64'(bus.pwrite), 64'(1));
      chk("t2_pwdata", 64'(bus.pwdata), 64'(32'h12345678));
      chk("t2_pstrb", 64'(bus.pstrb), 64'(4'hF));
      chk("t2_paddr", 64'({bus.paddr, bus.pprot}), 64'({32'h1000, 3'b001}));
      chk("t2_wr_early", 64'(bus.wr), 64'(0));
    end
    step(); bus.pready = 1'b0; bus.pslverr = 1'b0; settle();
    chk("t2_wr_n6", 64'(bus.wr), 64'(1));
    chk("t2_idle_n6", 64'(bus.psel), 64'(0));
    step(); settle();
    chk("t2_wr_one_cycle", 64'(bus.wr), 64'(0));

    // Illegal write grant during ACCESS
    step(); bus.rd_en = 1'b1; bus.araddr = 32'h44; bus.arprot = 3'b000;
    expect_rsp(1'b1, 32'hCAFEF00D, RESP_OKAY);
    settle();
    step(); bus.rd_en = 1'b0; settle();
    step(); bus.wr_en = 1'b1; bus.awaddr = 32'h2222; settle();
    chk("t3_no_aw_pop", 64'({bus.aw_pop, bus.w_pop}), 64'(0));
    chk("t3_in_access", 64'(bus.penable), 64'(1));
    step(); bus.wr_en = 1'b0; settle();
    chk("t3_perr", 64'(bus.protocol_err), 64'(1));
    chk("t3_req_kept", 64'({bus.pwrite, bus.paddr}), 64'({1'b0, 32'h44}));
    step(); bus.pready = 1'b1; bus.prdata = 32'hCAFEF00D; settle();
    chk("t3_perr_one_cycle", 64'(bus.protocol_err), 64'(0));
    step(); bus.pready = 1'b0; settle();
    chk("t3_rd", 64'(bus.rd), 64'(1));

    // Simultaneous grants in IDLE: read executes
    step(); bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.araddr = 32'h80; bus.awaddr = 32'h2000;
    expect_rsp(1'b1, 32'h11112222, RESP_SLVERR);
    settle();
    chk("t4_pops", 64'({bus.ar_pop, bus.aw_pop, bus.w_pop}), 64'(3'b100));
    step(); bus.rd_en = 1'b0; bus.wr_en = 1'b0; settle();
    chk("t4_perr", 64'(bus.protocol_err), 64'(1));
    chk("t4_read_req", 64'({bus.psel, bus.pwrite, bus.paddr}), 64'({1'b1, 1'b0, 32'h80}));
    step(); bus.pready = 1'b1; bus.prdata = 32'h11112222; bus.pslverr = 1'b1; settle();
    chk("t4_perr_one_cycle", 64'(bus.protocol_err), 64'(0));
    step(); bus.pready = 1'b0; bus.pslverr = 1'b0; settle();
    chk("t4_rd", 64'(bus.rd), 64'(1));

    // PREADY timeout on a read
    step(); bus.rd_en = 1'b1; bus.araddr = 32'hC0; bus.prdata = 32'hFFFFFFFF;
    expect_rsp(1'b1, 32'h0, RESP_SLVERR);
    settle();
    pen_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      step(); bus.rd_en = 1'b0; settle();
      if (bus.penable) pen_cnt++;
      if (k == 17) chk("t5_last_access", 64'({bus.psel, bus.penable}), 64'(2'b11));
    end
    chk("t5_penable_cycles", 64'(pen_cnt), 64'(16));
    step(); settle();
    chk("t5_done", 64'({bus.psel, bus.rd}), 64'(2'b01));
    step(); bus.pready = 1'b1; settle();
    chk("t5_idle", 64'({bus.psel, bus.penable, bus.rd}), 64'(0));
    step(); bus.pready = 1'b0; settle();
    chk("t5_idle_pready_ignored", 64'({bus.psel, bus.rd}), 64'(0));

    // Reset during ACCESS
    step(); bus.rd_en = 1'b1; bus.araddr = 32'h100; settle();
    step(); bus.rd_en = 1'b0; settle();
    step(); settle();
    chk("t6_in_access", 64'(bus.penable), 64'(1));
    #1; rstn = 1'b0; #1;
    chk("t6_async_clear", 64'({bus.psel, bus.penable}), 64'(0));
    chk("t6_async_paddr", 64'(bus.paddr), 64'(0));
    step(); step(); rstn = 1'b1;
    step(); bus.pready = 1'b1; settle();
    chk("t6_no_restart", 64'(bus.psel), 64'(0));
    step(); bus.pready = 1'b0; settle();
    chk("t6_no_resp", 64'({bus.rd, bus.r_push}), 64'(0));

    // Normal write after reset
    step(); bus.wr_en = 1'b1; bus.awaddr = 32'h3000; bus.awprot = 3'b000;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'h3;
    expect_rsp(1'b0, 32'h0, RESP_OKAY);
    settle();
    chk("t7_pops", 64'({bus.aw_pop, bus.w_pop}), 64'(2'b11));
    step(); bus.wr_en = 1'b0; settle();
    chk("t7_req", 64'({bus.pwdata, bus.pstrb}), 64'({32'hA5A5A5A5, 4'h3}));
    step(); bus.pready = 1'b1; settle();
    step(); bus.pready = 1'b0; settle();
    chk("t7_wr", 64'(bus.wr), 64'(1));
    step(); step(); settle();

    chk("ar_pop_count", 64'(n_ar), 64'(5));
    chk("aw_pop_count", 64'(n_aw), 64'(2));
    chk("w_pop_count", 64'(n_w), 64'(2));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
